// File: rtl/medidor_distancia_hcsr04.sv
// rtl/medidor_distancia_hcsr04.sv - HC-SR04 trigger generator and echo-width to centimetre converter
module medidor_distancia_hcsr04 #(
    parameter int CLOCK_HZ       = 50_000_000,
    parameter int TRIGGER_CICLOS = 500,
    parameter int CICLOS_POR_CM  = 2941,
    parameter int TIMEOUT_CICLOS = 1_500_000,
    parameter int LARGURA_DIST   = 9
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    medir,
    input  logic                    echo,
    output logic                    trigger,
    output logic [LARGURA_DIST-1:0] distancia,
    output logic                    pronto,
    output logic                    timeout,
    output logic                    ocupado
);

    localparam int CNT_MAX = (TIMEOUT_CICLOS > TRIGGER_CICLOS) ? TIMEOUT_CICLOS : TRIGGER_CICLOS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SW      = $clog2(CICLOS_POR_CM + 1);

    localparam logic [CW-1:0]           CNT_TRIG_FIM    = CW'(TRIGGER_CICLOS - 1);
    localparam logic [CW-1:0]           CNT_TIMEOUT_FIM = CW'(TIMEOUT_CICLOS - 1);
    localparam logic [SW-1:0]           SUB_FIM         = SW'(CICLOS_POR_CM - 1);
    localparam logic [LARGURA_DIST-1:0] DIST_MAX        = {LARGURA_DIST{1'b1}};

    if (CLOCK_HZ <= 0 || TRIGGER_CICLOS < 1 || CICLOS_POR_CM < 1 || TIMEOUT_CICLOS < 2) begin : g_param_invalido
        $error("medidor_distancia_hcsr04: invalid parameter set");
    end

    typedef enum logic [2:0] {
        OCIOSO,
        TRIGGER,
        ESPERA_ECHO,
        MEDE,
        FINAL,
        ERRO
    } estado_t;

    estado_t                 estado;
    logic [CW-1:0]           cnt;
    logic [SW-1:0]           sub;
    logic [LARGURA_DIST-1:0] cm;
    logic                    echo_s1;
    logic                    echo_s2;
    logic                    echo_ant;
    logic                    echo_sobe;
    logic                    echo_desce;

    // Both edges see the same synchronizer delay, so the measured width is unskewed.
    assign echo_sobe  = echo_s2 & ~echo_ant;
    assign echo_desce = ~echo_s2 & echo_ant;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= OCIOSO;
            cnt       <= '0;
            sub       <= '0;
            cm        <= '0;
            echo_s1   <= 1'b0;
            echo_s2   <= 1'b0;
            echo_ant  <= 1'b0;
            trigger   <= 1'b0;
            distancia <= '0;
            pronto    <= 1'b0;
            timeout   <= 1'b0;
            ocupado   <= 1'b0;
        end else begin
            echo_s1  <= echo;
            echo_s2  <= echo_s1;
            echo_ant <= echo_s2;
            pronto   <= 1'b0;

            case (estado)
                OCIOSO: begin
                    if (medir) begin
                        timeout <= 1'b0;
                        cnt     <= '0;
                        sub     <= '0;
                        cm      <= '0;
                        ocupado <= 1'b1;
                        trigger <= 1'b1;
                        estado  <= TRIGGER;
                    end
                end

                TRIGGER: begin
                    if (cnt == CNT_TRIG_FIM) begin
                        trigger <= 1'b0;
                        cnt     <= '0;
                        estado  <= ESPERA_ECHO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ESPERA_ECHO: begin
                    if (echo_sobe) begin
                        cnt    <= '0;
                        sub    <= '0;
                        cm     <= '0;
                        estado <= MEDE;
                    end else if (cnt == CNT_TIMEOUT_FIM) begin
                        estado <= ERRO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                MEDE: begin
                    // The clock on which the fall is seen is still an echo-high clock.
                    cnt <= cnt + 1'b1;
                    if (sub == SUB_FIM) begin
                        sub <= '0;
                        if (cm != DIST_MAX) begin
                            cm <= cm + 1'b1;
                        end
                    end else begin
                        sub <= sub + 1'b1;
                    end
                    if (echo_desce) begin
                        estado <= FINAL;
                    end else if (cnt == CNT_TIMEOUT_FIM) begin
                        estado <= ERRO;
                    end
                end

                FINAL: begin
                    distancia <= cm;
                    pronto    <= 1'b1;
                    ocupado   <= 1'b0;
                    estado    <= OCIOSO;
                end

                ERRO: begin
                    timeout <= 1'b1;
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end

                default: begin
                    trigger <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: doc/medidor_distancia_hcsr04.md
Name: medidor_distancia_hcsr04

Overview:
Ultrasonic range front-end that sits directly upstream of the cafeteira controller. One instance drives the water-tank sensor (trigger_agua/echo_agua) and one drives the cup sensor (trigger_xicara/echo_xicara). On a measurement request it produces the HC-SR04 trigger pulse and times the echo pulse. It returns the distance in whole centimetres, or flags a timeout if no valid echo arrives. The controller derives "sem agua" / "sem xicara" by comparing the returned distance against its own thresholds.

Parameters:
CLOCK_HZ, 50_000_000, system clock frequency.
TRIGGER_CICLOS, 500, trigger high width in clocks (10 us at 50 MHz).
CICLOS_POR_CM, 2941, echo clocks per centimetre (58.82 us/cm at 50 MHz).
TIMEOUT_CICLOS, 1_500_000, maximum wait for echo rise, and separately maximum echo high time (30 ms).
LARGURA_DIST, 9, width of the distance output in bits.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
medir  in  1  measurement request; sampled high for one or more clocks while idle.
echo  in  1  raw sensor echo; asynchronous to clock.
trigger  out  1  sensor trigger pulse.
distancia  out  LARGURA_DIST  last valid distance in cm.
pronto  out  1  one-clock pulse when a new valid distancia is loaded.
timeout  out  1  sticky flag: last measurement failed.
ocupado  out  1  high from request accept until pronto/timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM returns to OCIOSO.
  - Outputs: trigger=0, distancia=0, pronto=0, timeout=0, ocupado=0.
  - All counters cleared and synchronizer flops cleared.
  - Reset asserted mid-measurement aborts immediately; no pronto is emitted.
- Echo input: passes through a 2-flop synchronizer, followed by one more register for edge detection.
  - Rise = sync high and previous low; fall = sync low and previous high.
  - Echo edges are therefore seen 2-3 clocks late. This skew applies equally to both edges, so measured width is exact to ±1 clock.
- FSM states:
  - OCIOSO: ocupado=0. On medir=1, clear timeout and the cycle/cm counters, set ocupado=1, go to TRIGGER.
  - TRIGGER: trigger=1 for exactly TRIGGER_CICLOS clocks, then trigger=0 and go to ESPERA_ECHO.
  - ESPERA_ECHO: wait-counter increments each clock.
    - On rise: clear counters, go to MEDE.
    - If the counter reaches TIMEOUT_CICLOS first: go to ERRO.
  - MEDE: sub-counter increments each clock.
    - When it reaches CICLOS_POR_CM-1 it wraps to 0 and the cm counter increments.
    - The cm counter saturates at 2^LARGURA_DIST-1 (511) and never wraps.
    - Total echo-high clocks are counted in parallel. If they reach TIMEOUT_CICLOS, go to ERRO.
    - On fall: go to FINAL.
  - FINAL: one clock. Load distancia with the cm counter (truncated; partial cm discarded), pulse pronto=1 for this clock, set ocupado=0, return to OCIOSO.
  - ERRO: one clock. Set timeout=1, ocupado=0, leave distancia unchanged, return to OCIOSO. pronto is not asserted.
- medir while ocupado=1 is ignored and not queued. A medir held high continuously starts a new measurement on the first clock back in OCIOSO.
- An echo rise during TRIGGER is ignored; only edges observed in ESPERA_ECHO and MEDE count.
- An echo already high when ESPERA_ECHO is entered produces no rise. It is treated as "no rise" until it goes low and rises again, or the timeout expires.
- Latency: from request accept to trigger going high is 1 clock. From echo fall at the pin to pronto is 4 clocks.
- All outputs are registered. No combinational path exists from inputs to outputs.

Test Plan:
- Reset 2 us, then medir pulse; echo low throughout → trigger high exactly 500 clocks; ocupado=1; after 1_500_000 clocks in ESPERA_ECHO, timeout=1, ocupado=0, pronto never asserted, distancia=0.
- medir, echo rise 50 us after trigger falls, echo high 5882 us (294_100 clocks) → single pronto pulse, distancia=100, timeout=0.
- Echo high 2940 clocks (just under 1 cm) → distancia=0, pronto pulses. Echo high 2941 clocks → distancia=1.
- Echo held high for 30 ms → timeout=1, distancia keeps the previous value (100), no pronto. A following good 10 cm echo (29_410 clocks) clears timeout, distancia=10.
- Extra medir pulses during MEDE → ignored: exactly one trigger pulse and one pronto per accepted request.
- Assert reset=0 mid-echo → all outputs 0 within the same cycle (asynchronous). After release, a stale echo fall produces no pronto; a fresh medir measures normally.
